if_fetch_stage: RTL and testbench

Instruction-fetch stage of the 5-stage MIPS pipeline. It owns the PC register and the IF/ID pipeline register, and issues requests to a variable-latency instruction memory. It obeys the PC-write and IF/ID-write enables produced by the hazard detection unit and redirects on branch flush from ID. It feeds the IF/ID rs/rt fields back to the hazard detection unit.

---
 rtl/if_fetch_stage.sv | 160 ++++++++++++++++
 tb/tb_if_fetch_stage.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// IF stage: PC register, IF/ID register and variable-latency imem requester.
// Optional IF_STALL_CNT_EN adds a saturating stall-bubble counter port.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        pc_write_i,
    input  logic        if_id_write_i,
    input  logic        flush_i,
    input  logic [31:0] branch_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic [31:0] inst_o,
    output logic [31:0] pc_plus4_o,
    output logic        valid_o,
    output logic [4:0]  rs_o,
    output logic [4:0]  rt_o
`ifdef IF_STALL_CNT_EN
    ,
    output logic [15:0] stall_cnt_o
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD,
        DROP
    } state_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc_plus4;
        logic        valid;
    } if_id_t;

    localparam logic [31:0] RST_PC = RESET_PC & ~32'h3;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] hold_q, hold_d;
    if_id_t      if_id_q, if_id_d;
    if_id_t      bubble;
    logic        adv;
    logic        redirect;
    logic        stall_bubble;
    logic [31:0] target;
    logic [31:0] seq;

    assign adv      = pc_write_i & if_id_write_i;
    assign redirect = flush_i & adv;
    assign target   = branch_target_i & ~32'h3;
    assign seq      = addr_q + 32'd4;
    assign bubble   = '{inst: 32'd0, pc_plus4: if_id_q.pc_plus4, valid: 1'b0};

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        addr_d       = addr_q;
        hold_d       = hold_q;
        if_id_d      = if_id_q;
        stall_bubble = 1'b0;
        unique case (state_q)
            IDLE: begin
                state_d = FETCH;
                addr_d  = pc_q;
            end
            FETCH: begin
                if (redirect) begin
                    if_id_d = bubble;
                    pc_d    = target;
                    // an outstanding request is never withdrawn
                    if (imem_ack_i) addr_d = target;
                    else state_d = DROP;
                end else if (imem_ack_i) begin
                    if (adv) begin
                        if_id_d = '{inst: imem_data_i, pc_plus4: seq, valid: 1'b1};
                        pc_d    = seq;
                        addr_d  = seq;
                    end else begin
                        hold_d  = imem_data_i;
                        state_d = HOLD;
                    end
                end else if (adv) begin
                    if_id_d      = bubble;
                    stall_bubble = 1'b1;
                end
            end
            HOLD: begin
                if (redirect) begin
                    if_id_d = bubble;
                    pc_d    = target;
                    addr_d  = target;
                    state_d = FETCH;
                end else if (adv) begin
                    if_id_d = '{inst: hold_q, pc_plus4: seq, valid: 1'b1};
                    pc_d    = seq;
                    addr_d  = seq;
                    state_d = FETCH;
                end
            end
            DROP: begin
                if (adv) begin
                    if_id_d      = bubble;
                    stall_bubble = ~flush_i;
                end
                if (redirect) pc_d = target;
                if (imem_ack_i) begin
                    addr_d  = pc_d;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            pc_q    <= RST_PC;
            addr_q  <= RST_PC;
            hold_q  <= 32'd0;
            if_id_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            hold_q  <= hold_d;
            if_id_q <= if_id_d;
        end
    end

`ifdef IF_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) stall_cnt_q <= 16'd0;
        else if (stall_bubble && stall_cnt_q != 16'hFFFF)
            stall_cnt_q <= stall_cnt_q + 16'd1;
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    logic unused_stall;
    assign unused_stall = stall_bubble;
`endif

    assign imem_req_o  = (state_q == FETCH) || (state_q == DROP);
    assign imem_addr_o = addr_q;
    assign inst_o      = if_id_q.inst;
    assign pc_plus4_o  = if_id_q.pc_plus4;
    assign valid_o     = if_id_q.valid;
    assign rs_o        = if_id_q.inst[25:21];
    assign rt_o        = if_id_q.inst[20:16];

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a wait-state imem responder.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_write;
    logic        if_id_write;
    logic        flush;
    logic [31:0] target;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] data;
    logic [31:0] inst;
    logic [31:0] pc4;
    logic        valid;
    logic [4:0]  rs;
    logic [4:0]  rt;
`ifdef IF_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    int waits    = 0;
    int wcnt     = 0;
    logic mem_en = 1'b1;

    always #5 clk = ~clk;

    if_fetch_stage dut (
        .clk_i(clk),
        .rst_i(rst),
        .pc_write_i(pc_write),
        .if_id_write_i(if_id_write),
        .flush_i(flush),
        .branch_target_i(target),
        .imem_req_o(req),
        .imem_addr_o(addr),
        .imem_ack_i(ack),
        .imem_data_i(data),
        .inst_o(inst),
        .pc_plus4_o(pc4),
        .valid_o(valid),
        .rs_o(rs),
        .rt_o(rt)
`ifdef IF_STALL_CNT_EN
        ,
        .stall_cnt_o(stall_cnt)
`endif
    );

    function automatic logic [31:0] w(input logic [31:0] a);
        return 32'hC000_0000 ^ (a << 19) ^ (a >> 2);
    endfunction

    function automatic logic [31:0] rs_of(input logic [31:0] x);
        return {27'd0, x[25:21]};
    endfunction

    function automatic logic [31:0] rt_of(input logic [31:0] x);
        return {27'd0, x[20:16]};
    endfunction

    assign ack  = mem_en && req && (wcnt >= waits);
    assign data = ack ? w(addr) : 32'hDEAD_BEEF;

    always @(posedge clk) begin
        if (rst || !req || ack) wcnt <= 0;
        else wcnt <= wcnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] ei,
                            input logic [31:0] ep, input logic ev);
        chk({tag, "_inst"}, inst, ei);
        chk({tag, "_pc4"}, pc4, ep);
        chk({tag, "_valid"}, {31'd0, valid}, {31'd0, ev});
    endtask

    initial begin
        rst = 1'b1;
        pc_write = 1'b1;
        if_id_write = 1'b1;
        flush = 1'b0;
        target = 32'd0;
        tick();
        tick();
        chk("rst_req", {31'd0, req}, 32'd0);
        chk("rst_addr", addr, 32'd0);
        chk_ifid("rst", 32'd0, 32'd0, 1'b0);
        chk("rst_rs", {27'd0, rs}, 32'd0);
        chk("rst_rt", {27'd0, rt}, 32'd0);
`ifdef IF_STALL_CNT_EN
        chk("rst_stall", {16'd0, stall_cnt}, 32'd0);
`endif

        // zero-wait streaming
        rst = 1'b0;
        tick();
        chk("idle_req", {31'd0, req}, 32'd1);
        chk("idle_addr", addr, 32'd0);
        chk("idle_valid", {31'd0, valid}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_ifid("zw", w(32'(i * 4)), 32'(i * 4 + 4), 1'b1);
            chk("zw_addr", addr, 32'(i * 4 + 4));
            chk("zw_rs", {27'd0, rs}, rs_of(w(32'(i * 4))));
            chk("zw_rt", {27'd0, rt}, rt_of(w(32'(i * 4))));
        end

        // two wait states per access
        waits = 2;
        for (int k = 0; k < 2; k++) begin
            for (int b = 0; b < 2; b++) begin
                tick();
                chk_ifid("ws_bub", 32'd0, 32'(12 + k * 4), 1'b0);
                chk("ws_addr", addr, 32'(12 + k * 4));
            end
            tick();
            chk_ifid("ws_ld", w(32'(12 + k * 4)), 32'(16 + k * 4), 1'b1);
`ifdef IF_STALL_CNT_EN
            chk("ws_stall", {16'd0, stall_cnt}, 32'(2 * (k + 1)));
`endif
        end

        // ack while stalled -> HOLD
        waits = 0;
        pc_write = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("hold_req", {31'd0, req}, 32'd0);
            chk("hold_addr", addr, 32'h14);
            chk_ifid("hold", w(32'h10), 32'h14, 1'b1);
        end
        pc_write = 1'b1;
        tick();
        chk_ifid("hold_rel", w(32'h14), 32'h18, 1'b1);
        chk("hold_rel_req", {31'd0, req}, 32'd1);
        chk("hold_rel_addr", addr, 32'h18);
        tick();
        tick();
        chk("pre_fl_addr", addr, 32'h20);
        chk_ifid("pre_fl", w(32'h1C), 32'h20, 1'b1);

        // flush with a pending request to 0x20
        mem_en = 1'b0;
        flush = 1'b1;
        target = 32'h100;
        tick();
        flush = 1'b0;
        chk_ifid("drop_bub", 32'd0, 32'h20, 1'b0);
        chk("drop_req", {31'd0, req}, 32'd1);
        chk("drop_addr", addr, 32'h20);
        tick();
        chk("drop_addr2", addr, 32'h20);
        chk("drop_valid2", {31'd0, valid}, 32'd0);
        mem_en = 1'b1;
        tick();
        chk("drop_ack_addr", addr, 32'h100);
        chk_ifid("drop_ack", 32'd0, 32'h20, 1'b0);
        tick();
        chk_ifid("redir", w(32'h100), 32'h104, 1'b1);

        // flush ignored while stalled, honoured afterwards
        if_id_write = 1'b0;
        flush = 1'b1;
        target = 32'h200;
        tick();
        tick();
        chk("nsf_addr", addr, 32'h104);
        chk("nsf_req", {31'd0, req}, 32'd0);
        chk_ifid("nsf", w(32'h100), 32'h104, 1'b1);
        if_id_write = 1'b1;
        tick();
        flush = 1'b0;
        chk_ifid("nsf_fl", 32'd0, 32'h104, 1'b0);
        chk("nsf_fl_addr", addr, 32'h200);
        chk("nsf_fl_req", {31'd0, req}, 32'd1);
        tick();
        chk_ifid("nsf_ld", w(32'h200), 32'h204, 1'b1);

        // PC wrap at the top of the address space
        flush = 1'b1;
        target = 32'hFFFF_FFFC;
        tick();
        flush = 1'b0;
        chk("wrap_addr", addr, 32'hFFFF_FFFC);
        chk("wrap_bub", {31'd0, valid}, 32'd0);
        tick();
        chk_ifid("wrap", w(32'hFFFF_FFFC), 32'h0, 1'b1);
        chk("wrap_next", addr, 32'h0);
        tick();
        chk_ifid("wrap2", w(32'h0), 32'h4, 1'b1);

        // reset abandons an outstanding request
        mem_en = 1'b0;
        tick();
        chk("pend_req", {31'd0, req}, 32'd1);
        rst = 1'b1;
        tick();
        chk("mid_rst_req", {31'd0, req}, 32'd0);
        chk("mid_rst_addr", addr, 32'd0);
        chk_ifid("mid_rst", 32'd0, 32'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
